// File: rtl/simax_pkg.sv
// Shared definitions for the mesh preload/drain blocks: sequencer states,
// default geometry and the {row, col} address packing used on the mesh side.
package simax_pkg;

    localparam int DEF_DW    = 8;
    localparam int DEF_ROWS  = 2;
    localparam int DEF_COLS  = 8;
    localparam int DEF_ROW_W = 1;
    localparam int DEF_COL_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_FLUSH  = 2'd2,
        ST_LAUNCH = 2'd3
    } seq_state_t;

    // Row occupies the bits above the col_w-bit column field; callers truncate
    // the result to ROW_W+COL_W.
    function automatic logic [31:0] pack_addr(input logic [15:0] row,
                                              input logic [15:0] col,
                                              input int          col_w);
        return ({16'd0, row} << col_w) | {16'd0, col};
    endfunction

endpackage

// File: rtl/rc_counter.sv
// Row-major row/column wrap counter; also intended for the result-drain reader.
// clr takes priority over inc; the final position wraps back to {0, 0}.
module rc_counter
    import simax_pkg::*;
#(
    parameter int ROWS  = DEF_ROWS,
    parameter int COLS  = DEF_COLS,
    parameter int ROW_W = DEF_ROW_W,
    parameter int COL_W = DEF_COL_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [ROW_W-1:0] row,
    output logic [COL_W-1:0] col,
    output logic             last
);

    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(COLS - 1);

    logic [ROW_W-1:0] r_row;
    logic [COL_W-1:0] r_col;
    logic             w_col_wrap;
    logic             w_row_wrap;

    assign w_col_wrap = (r_col == COL_MAX);
    assign w_row_wrap = (r_row == ROW_MAX);
    assign last       = w_col_wrap && w_row_wrap;
    assign row        = r_row;
    assign col        = r_col;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row <= '0;
            r_col <= '0;
        end else if (clr) begin
            r_row <= '0;
            r_col <= '0;
        end else if (inc) begin
            if (w_col_wrap) begin
                r_col <= '0;
                r_row <= w_row_wrap ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/preload_sequencer.sv
// Weight-preload initiator: streams ROWS*COLS weights into the mesh in
// row-major order, then pulses start/done to launch the compute controller.
module preload_sequencer
    import simax_pkg::*;
#(
    parameter int DW    = DEF_DW,
    parameter int ROWS  = DEF_ROWS,
    parameter int COLS  = DEF_COLS,
    parameter int ROW_W = DEF_ROW_W,
    parameter int COL_W = DEF_COL_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_req,
    input  logic                    abort,
    input  logic                    w_valid,
    input  logic signed [DW-1:0]    w_data,
    output logic                    w_ready,
    output logic                    preload_valid,
    output logic [ROW_W+COL_W-1:0]  preload_addr,
    output logic signed [DW-1:0]    preload_data,
    output logic                    start,
    output logic                    busy,
    output logic                    done
);

    localparam int ADDR_W = ROW_W + COL_W;

    seq_state_t              r_state;
    seq_state_t              w_next;
    logic                    w_beat;
    logic                    w_abort;
    logic                    w_clr;
    logic                    w_last;
    logic [ROW_W-1:0]        w_row;
    logic [COL_W-1:0]        w_col;
    logic                    r_valid;
    logic [ADDR_W-1:0]       r_addr;
    logic signed [DW-1:0]    r_data;
    logic                    r_start;

    // w_ready and busy decode straight from the state register so the source
    // sees ready in the cycle right after load_req.
    assign w_ready = (r_state == ST_LOAD);
    assign busy    = (r_state != ST_IDLE);
    assign w_beat  = w_ready && w_valid;
    assign w_abort = abort && ((r_state == ST_LOAD) || (r_state == ST_FLUSH));
    assign w_clr   = ((r_state == ST_IDLE) && load_req) || w_abort;

    rc_counter #(
        .ROWS  (ROWS),
        .COLS  (COLS),
        .ROW_W (ROW_W),
        .COL_W (COL_W)
    ) u_rc (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_clr),
        .inc  (w_beat),
        .row  (w_row),
        .col  (w_col),
        .last (w_last)
    );

    // NOTE: next-state defaults to the current state before the case so no
    // path leaves w_next unassigned and no latch is inferred.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:   if (load_req) w_next = ST_LOAD;
            ST_LOAD: begin
                if (abort)                w_next = ST_IDLE;
                else if (w_beat && w_last) w_next = ST_FLUSH;
            end
            ST_FLUSH:  w_next = abort ? ST_IDLE : ST_LAUNCH;
            ST_LAUNCH: w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
            r_start <= 1'b0;
        end else begin
            r_state <= w_next;
            r_valid <= w_beat;
            if (w_beat) begin
                r_addr <= ADDR_W'(pack_addr(16'(w_row), 16'(w_col), COL_W));
                r_data <= w_data;
            end
            // An abort during FLUSH cancels the launch.
            r_start <= (r_state == ST_FLUSH) && !abort;
        end
    end

    assign preload_valid = r_valid;
    assign preload_addr  = r_addr;
    assign preload_data  = r_data;
    assign start         = r_start;
    assign done          = r_start;

endmodule
